// File: rtl/mips_retire_monitor_pkg.sv
// Shared definitions for the retire monitor: FSM encoding, special instruction encodings,
// and the small arithmetic helpers used by the counters and the signature fold.
package mips_retire_monitor_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_RUN     = 2'd1;
   localparam logic [1:0] ST_HALTED  = 2'd2;
   localparam logic [1:0] ST_TIMEOUT = 2'd3;

   // beq $0,$0,-1 : a branch that targets itself
   localparam logic [31:0] SELF_BRANCH = 32'h1000FFFF;
   localparam logic [31:0] SYSCALL     = 32'h0000000C;

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFFFFFF) ? v : v + 32'd1;
   endfunction

   function automatic logic [31:0] sig_fold(input logic [31:0] sig,
                                            input logic [4:0]  addr,
                                            input logic [31:0] data);
      return {sig[30:0], sig[31]} ^ data ^ {27'b0, addr};
   endfunction

endpackage

// File: rtl/mips_sig_accum.sv
// Rolling writeback signature: rotate-left-by-one, then xor in data and destination index.
// Qualification (state, $0 filtering) is done by the caller through en.
module mips_sig_accum
   import mips_retire_monitor_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [4:0]  addr,
   input  logic [31:0] data,
   output logic [31:0] sig
);

   logic [31:0] sig_q;
   logic [31:0] sig_d;

   always_comb begin
      sig_d = sig_q;
      if (en) begin
         sig_d = sig_fold(sig_q, addr, data);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sig_q <= 32'd0;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign sig = sig_q;

endmodule

// File: rtl/mips_retire_monitor.sv
// Watches the single-cycle core's retire/writeback stream, decides when the program has ended
// (syscall, self-branch loop, or watchdog) and keeps cycle/retire counts plus a writeback signature.
module mips_retire_monitor
   import mips_retire_monitor_pkg::*;
#(
   parameter int          MAX_CYCLES = 1000,
   parameter int          SELF_LOOPS = 2,
   parameter logic [31:0] HALT_INSTR = 32'h0000000C
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        retire_valid,
   input  logic [31:0] retire_pc,
   input  logic [31:0] retire_instr,
   input  logic        wb_en,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_data,
   output logic        done,
   output logic        timeout,
   output logic [31:0] halt_pc,
   output logic [31:0] cycle_cnt,
   output logic [31:0] retire_cnt,
   output logic [31:0] signature
);

   logic [1:0]  state_q, state_d;
   logic [31:0] cycle_q, cycle_d;
   logic [31:0] retire_q, retire_d;
   logic [31:0] loop_pc_q, loop_pc_d;
   logic [31:0] loop_cnt_q, loop_cnt_d;
   logic [31:0] halt_pc_q, halt_pc_d;
   logic        done_q, done_d;
   logic        timeout_q, timeout_d;
   logic        active;
   logic        halt_det;

   // The first valid retirement seen in IDLE is already treated as a RUN cycle.
   assign active = (state_q == ST_RUN) || ((state_q == ST_IDLE) && retire_valid);

   always_comb begin
      state_d    = state_q;
      cycle_d    = cycle_q;
      retire_d   = retire_q;
      loop_pc_d  = loop_pc_q;
      loop_cnt_d = loop_cnt_q;
      halt_pc_d  = halt_pc_q;
      done_d     = done_q;
      timeout_d  = timeout_q;
      halt_det   = 1'b0;
      if (active) begin
         state_d = ST_RUN;
         cycle_d = sat_inc32(cycle_q);
         if (retire_valid) begin
            retire_d = sat_inc32(retire_q);
            if (retire_instr == SELF_BRANCH) begin
               if ((loop_cnt_q != 32'd0) && (retire_pc == loop_pc_q)) begin
                  loop_cnt_d = sat_inc32(loop_cnt_q);
               end else begin
                  loop_cnt_d = 32'd1;
                  loop_pc_d  = retire_pc;
               end
            end else begin
               loop_cnt_d = 32'd0;
            end
            halt_det = (retire_instr == HALT_INSTR) ||
                       ((retire_instr == SELF_BRANCH) && (loop_cnt_d >= 32'(SELF_LOOPS)));
         end
         // A halt on the watchdog's final cycle still counts as a clean finish.
         if (halt_det) begin
            state_d   = ST_HALTED;
            done_d    = 1'b1;
            halt_pc_d = retire_pc;
         end else if (cycle_d >= 32'(MAX_CYCLES)) begin
            state_d   = ST_TIMEOUT;
            timeout_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cycle_q    <= 32'd0;
         retire_q   <= 32'd0;
         loop_pc_q  <= 32'd0;
         loop_cnt_q <= 32'd0;
         halt_pc_q  <= 32'd0;
         done_q     <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cycle_q    <= cycle_d;
         retire_q   <= retire_d;
         loop_pc_q  <= loop_pc_d;
         loop_cnt_q <= loop_cnt_d;
         halt_pc_q  <= halt_pc_d;
         done_q     <= done_d;
         timeout_q  <= timeout_d;
      end
   end

   mips_sig_accum u_sig (
      .clk  (clk),
      .rst  (rst),
      .en   (active && wb_en && (wb_addr != 5'd0)),
      .addr (wb_addr),
      .data (wb_data),
      .sig  (signature)
   );

   assign done       = done_q;
   assign timeout    = timeout_q;
   assign halt_pc    = halt_pc_q;
   assign cycle_cnt  = cycle_q;
   assign retire_cnt = retire_q;

endmodule
